// File: rtl/bitlet_requant_packer_if.sv
// Accumulator-result input and packed-word output bus for bitlet_requant_packer.
// slave = packer side, master = accumulator/consumer side.
interface bitlet_requant_packer_if #(
  parameter int WID_ACC = 32,
  parameter int WID_OUT = 8,
  parameter int N_PACK  = 4
);
  localparam int CNT_W = $clog2(N_PACK + 1);

  logic                        acc_vld;
  logic signed [WID_ACC-1:0]   acc;
  logic                        flush;
  logic                        out_vld;
  logic                        out_rdy;
  logic [N_PACK*WID_OUT-1:0]   out_data;
  logic [CNT_W-1:0]            out_cnt;

  modport slave (
    input  acc_vld, acc, flush, out_rdy,
    output out_vld, out_data, out_cnt
  );

  modport master (
    output acc_vld, acc, flush, out_rdy,
    input  out_vld, out_data, out_cnt
  );
endinterface

// File: rtl/bitlet_requant_packer.sv
// Rounds/shifts accumulator results, saturates to WID_OUT lanes, packs N_PACK per word into a FIFO.
// Latency: 2 edges from last lane (or flush) to out_vld on an empty FIFO; 1 result/cycle in, 1 word/cycle out.
// Never back-pressures acc input; pushes into a full FIFO are dropped (ovf_err). BITLET_REQ_RELU_EN zeroes negatives.
module bitlet_requant_packer #(
  parameter int WID_ACC    = 32,
  parameter int WID_OUT    = 8,
  parameter int N_PACK     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4:0]                cfg_shift,
  bitlet_requant_packer_if.slave    bus,
  output logic                      ovf_err,
  output logic [15:0]               sat_cnt
);
  localparam int CNT_W  = $clog2(N_PACK + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WORD_W = N_PACK * WID_OUT;
  localparam int QMAX_I = 2 ** (WID_OUT - 1) - 1;
  localparam logic signed [WID_ACC:0] Q_MAX = (WID_ACC + 1)'(QMAX_I);
  localparam logic signed [WID_ACC:0] Q_MIN = (WID_ACC + 1)'(-QMAX_I - 1);

  // S1: round-half-up arithmetic shift, one guard bit so the rounding add cannot wrap
  logic signed [WID_ACC:0] acc_ext;
  logic signed [WID_ACC:0] rnd_add;
  logic signed [WID_ACC:0] s1_r_nxt;
  logic [4:0]              sh_m1;

  always_comb begin
    acc_ext = {bus.acc[WID_ACC-1], bus.acc};
    sh_m1   = cfg_shift - 5'd1;
    rnd_add = '0;
    if (cfg_shift != 5'd0) begin
      rnd_add = {{WID_ACC{1'b0}}, 1'b1} << sh_m1;
    end
    s1_r_nxt = (acc_ext + rnd_add) >>> cfg_shift;
  end

  logic                    s1_vld;
  logic                    s1_flush;
  logic signed [WID_ACC:0] s1_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_flush <= 1'b0;
      s1_r     <= '0;
    end else begin
      s1_vld   <= bus.acc_vld;
      s1_flush <= bus.flush;
      s1_r     <= s1_r_nxt;
    end
  end

  // S2: optional ReLU, clamp, lane insert and word-push decision
  logic signed [WID_ACC:0] r_eff;
  logic [WID_OUT-1:0]      q;
  logic                    clip;
  logic [WID_OUT-1:0]      lanes     [N_PACK];
  logic [WID_OUT-1:0]      lanes_nxt [N_PACK];
  logic [CNT_W-1:0]        lane_idx;
  logic [CNT_W-1:0]        cnt_after;
  logic                    push;
  logic [WORD_W-1:0]       word_dat;

  always_comb begin
`ifdef BITLET_REQ_RELU_EN
    r_eff = s1_r[WID_ACC] ? '0 : s1_r;
`else
    r_eff = s1_r;
`endif
    clip = 1'b0;
    q    = r_eff[WID_OUT-1:0];
    if (r_eff > Q_MAX) begin
      q    = Q_MAX[WID_OUT-1:0];
      clip = 1'b1;
    end else if (r_eff < Q_MIN) begin
      q    = Q_MIN[WID_OUT-1:0];
      clip = 1'b1;
    end

    lanes_nxt = lanes;
    word_dat  = '0;
    for (int i = 0; i < N_PACK; i++) begin
      if (s1_vld && (lane_idx == CNT_W'(i))) begin
        lanes_nxt[i] = q;
      end
      word_dat[i*WID_OUT +: WID_OUT] = lanes_nxt[i];
    end

    // a same-cycle S1 result counts toward a flushed word
    cnt_after = lane_idx + CNT_W'(s1_vld);
    push      = (cnt_after == CNT_W'(N_PACK)) || (s1_flush && (cnt_after != '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_idx <= '0;
      for (int i = 0; i < N_PACK; i++) lanes[i] <= '0;
    end else if (push) begin
      lane_idx <= '0;
      for (int i = 0; i < N_PACK; i++) lanes[i] <= '0;
    end else begin
      lane_idx <= cnt_after;
      lanes    <= lanes_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (s1_vld && clip && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

  // Output FIFO; a simultaneous pop frees the slot for a push into a full FIFO
  logic [WORD_W-1:0] mem_dat [FIFO_DEPTH];
  logic [CNT_W-1:0]  mem_cnt [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    fill;
  logic              full;
  logic              pop;
  logic              wr_en;

  assign full  = (fill == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop   = bus.out_vld && bus.out_rdy;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_dat[wr_ptr] <= word_dat;
      mem_cnt[wr_ptr] <= cnt_after;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill    <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      fill <= fill + (PTR_W + 1)'(wr_en) - (PTR_W + 1)'(pop);
      if (push && !wr_en) ovf_err <= 1'b1;
    end
  end

  assign bus.out_vld  = (fill != '0);
  assign bus.out_data = bus.out_vld ? mem_dat[rd_ptr] : '0;
  assign bus.out_cnt  = bus.out_vld ? mem_cnt[rd_ptr] : '0;
endmodule

// File: tb/tb_bitlet_requant_packer.sv
// Directed self-checking bench for bitlet_requant_packer; expectations follow BITLET_REQ_RELU_EN when defined.
module tb_bitlet_requant_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  cfg_shift;
  logic        ovf_err;
  logic [15:0] sat_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  bitlet_requant_packer_if bus ();

  bitlet_requant_packer dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_shift (cfg_shift),
    .bus       (bus.slave),
    .ovf_err   (ovf_err),
    .sat_cnt   (sat_cnt)
  );

  task automatic drive(input logic v, input logic [31:0] a, input logic f);
    @(negedge clk);
    bus.acc_vld = v;
    bus.acc     = a;
    bus.flush   = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; bus.acc_vld = 1'b0; bus.acc = '0; bus.flush = 1'b0;
    bus.out_rdy = 1'b1; cfg_shift = 5'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_vld(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_vld === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; bus.acc_vld = 1'b1; bus.acc = 32'd5; bus.flush = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.out_vld !== 1'b0)   begin n_bad++; $display("FAIL rst_out_vld: got %b want 0", bus.out_vld); end
    n_cmp++; if (bus.out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
    n_cmp++; if (bus.out_cnt !== 3'd0)   begin n_bad++; $display("FAIL rst_out_cnt: got %0d want 0", bus.out_cnt); end
    n_cmp++; if (ovf_err !== 1'b0)       begin n_bad++; $display("FAIL rst_ovf_err: got %b want 0", ovf_err); end
    n_cmp++; if (sat_cnt !== 16'd0)      begin n_bad++; $display("FAIL rst_sat_cnt: got %0d want 0", sat_cnt); end
    rst = 1'b0; bus.acc_vld = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_vld !== 1'b0)   begin n_bad++; $display("FAIL rst_release_vld: got %b want 0", bus.out_vld); end
  endtask

  task automatic test_packing;
    do_reset();
    drive(1'b1, 32'd1, 1'b0);
    drive(1'b1, 32'd2, 1'b0);
    drive(1'b1, 32'd3, 1'b0);
    drive(1'b1, 32'd4, 1'b0);
    drive(1'b0, 32'd0, 1'b0);
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL pack_early_vld: got %b want 0", bus.out_vld); end
    @(negedge clk);
    n_cmp++; if (bus.out_vld !== 1'b1) begin n_bad++; $display("FAIL pack_vld: got %b want 1", bus.out_vld); end
    n_cmp++; if (bus.out_data !== 32'h04030201) begin n_bad++; $display("FAIL pack_data: got %h want 04030201", bus.out_data); end
    n_cmp++; if (bus.out_cnt !== 3'd4) begin n_bad++; $display("FAIL pack_cnt: got %0d want 4", bus.out_cnt); end
    @(negedge clk);
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL pack_popped: got %b want 0", bus.out_vld); end
  endtask

  task automatic test_round_sat;
    bit got;
    logic [31:0] exp_w0, exp_w1, exp_w2;
    logic [15:0] exp_sat;
`ifdef BITLET_REQ_RELU_EN
    exp_w0 = 32'h007F0002; exp_w1 = 32'h00010002; exp_w2 = 32'h00000100; exp_sat = 16'd1;
`else
    exp_w0 = 32'h807FFF02; exp_w1 = 32'h0001FF02; exp_w2 = 32'h000001FF; exp_sat = 16'd2;
`endif
    do_reset();
    cfg_shift = 5'd4;
    drive(1'b1, 32'd24, 1'b0);
    drive(1'b1, -32'sd24, 1'b0);
    drive(1'b1, 32'd5000, 1'b0);
    drive(1'b1, -32'sd5000, 1'b0);
    drive(1'b0, 32'd0, 1'b0);
    wait_vld(got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL rs4_timeout: got no word want out_vld"); end
    n_cmp++; if (bus.out_data !== exp_w0) begin n_bad++; $display("FAIL rs4_data: got %h want %h", bus.out_data, exp_w0); end
    n_cmp++; if (sat_cnt !== exp_sat) begin n_bad++; $display("FAIL rs4_sat_cnt: got %0d want %0d", sat_cnt, exp_sat); end

    @(negedge clk);
    cfg_shift = 5'd1;
    drive(1'b1, 32'd3, 1'b0);
    drive(1'b1, -32'sd3, 1'b0);
    drive(1'b1, 32'd1, 1'b0);
    drive(1'b1, -32'sd1, 1'b0);
    drive(1'b0, 32'd0, 1'b0);
    wait_vld(got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL rs1_timeout: got no word want out_vld"); end
    n_cmp++; if (bus.out_data !== exp_w1) begin n_bad++; $display("FAIL rs1_data: got %h want %h", bus.out_data, exp_w1); end

    @(negedge clk);
    cfg_shift = 5'd31;
    drive(1'b1, 32'h80000000, 1'b0);
    drive(1'b1, 32'h7FFFFFFF, 1'b0);
    drive(1'b1, -32'sd5, 1'b1);
    drive(1'b0, 32'd0, 1'b0);
    wait_vld(got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL rs31_timeout: got no word want out_vld"); end
    n_cmp++; if (bus.out_data !== exp_w2) begin n_bad++; $display("FAIL rs31_data: got %h want %h", bus.out_data, exp_w2); end
    n_cmp++; if (bus.out_cnt !== 3'd3) begin n_bad++; $display("FAIL rs31_cnt: got %0d want 3", bus.out_cnt); end
    n_cmp++; if (sat_cnt !== exp_sat) begin n_bad++; $display("FAIL rs31_sat_cnt: got %0d want %0d", sat_cnt, exp_sat); end
  endtask

  task automatic test_flush;
    bit got;
    bit seen;
    do_reset();
    drive(1'b1, 32'd5, 1'b0);
    drive(1'b1, 32'd6, 1'b0);
    drive(1'b0, 32'd0, 1'b1);
    drive(1'b0, 32'd0, 1'b0);
    wait_vld(got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL flush2_timeout: got no word want out_vld"); end
    n_cmp++; if (bus.out_data !== 32'h00000605) begin n_bad++; $display("FAIL flush2_data: got %h want 00000605", bus.out_data); end
    n_cmp++; if (bus.out_cnt !== 3'd2) begin n_bad++; $display("FAIL flush2_cnt: got %0d want 2", bus.out_cnt); end

    @(negedge clk);
    drive(1'b0, 32'd0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'd0, 1'b0);
      if (bus.out_vld !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL flush_empty: got a word want none"); end

    drive(1'b1, 32'd7, 1'b0);
    drive(1'b1, 32'd8, 1'b0);
    drive(1'b1, 32'd9, 1'b1);
    drive(1'b0, 32'd0, 1'b0);
    wait_vld(got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL flush3_timeout: got no word want out_vld"); end
    n_cmp++; if (bus.out_data !== 32'h00090807) begin n_bad++; $display("FAIL flush3_data: got %h want 00090807", bus.out_data); end
    n_cmp++; if (bus.out_cnt !== 3'd3) begin n_bad++; $display("FAIL flush3_cnt: got %0d want 3", bus.out_cnt); end
  endtask

  task automatic test_relu;
    bit got;
    logic [31:0] exp_d;
    logic [15:0] exp_sat;
`ifdef BITLET_REQ_RELU_EN
    exp_d = 32'h00000000; exp_sat = 16'd0;
`else
    exp_d = 32'h000080FF; exp_sat = 16'd1;
`endif
    do_reset();
    cfg_shift = 5'd4;
    drive(1'b1, -32'sd24, 1'b0);
    drive(1'b1, -32'sd5000, 1'b1);
    drive(1'b0, 32'd0, 1'b0);
    wait_vld(got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL relu_timeout: got no word want out_vld"); end
    n_cmp++; if (bus.out_data !== exp_d) begin n_bad++; $display("FAIL relu_data: got %h want %h", bus.out_data, exp_d); end
    n_cmp++; if (bus.out_cnt !== 3'd2) begin n_bad++; $display("FAIL relu_cnt: got %0d want 2", bus.out_cnt); end
    n_cmp++; if (sat_cnt !== exp_sat) begin n_bad++; $display("FAIL relu_sat_cnt: got %0d want %0d", sat_cnt, exp_sat); end
  endtask

  task automatic push_five_words;
    for (int w = 0; w < 5; w++)
      for (int j = 0; j < 4; j++)
        drive(1'b1, 32'(16 * w + j + 1), 1'b0);
  endtask

  task automatic test_overflow;
    logic [31:0] exp_w [5];
    exp_w = '{32'h04030201, 32'h14131211, 32'h24232221, 32'h34333231, 32'h44434241};
    do_reset();
    bus.out_rdy = 1'b0;
    push_five_words();
    drive(1'b0, 32'd0, 1'b0);
    idle(2);
    n_cmp++; if (ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", ovf_err); end
    n_cmp++; if (bus.out_data !== exp_w[0]) begin n_bad++; $display("FAIL ovf_head: got %h want %h", bus.out_data, exp_w[0]); end
    idle(2);
    n_cmp++; if (bus.out_data !== exp_w[0]) begin n_bad++; $display("FAIL ovf_hold_data: got %h want %h", bus.out_data, exp_w[0]); end
    n_cmp++; if (bus.out_cnt !== 3'd4) begin n_bad++; $display("FAIL ovf_hold_cnt: got %0d want 4", bus.out_cnt); end
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.out_vld !== 1'b1 || bus.out_data !== exp_w[i]) begin
        n_bad++; $display("FAIL ovf_drain%0d: got vld=%b %h want vld=1 %h", i, bus.out_vld, bus.out_data, exp_w[i]);
      end
      @(negedge clk);
    end
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL ovf_empty: got %b want 0", bus.out_vld); end
    n_cmp++; if (ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", ovf_err); end
  endtask

  task automatic test_full_pushpop;
    logic [31:0] exp_w [5];
    exp_w = '{32'h04030201, 32'h14131211, 32'h24232221, 32'h34333231, 32'h44434241};
    do_reset();
    bus.out_rdy = 1'b0;
    push_five_words();
    drive(1'b0, 32'd0, 1'b0);
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus.out_vld !== 1'b1 || bus.out_data !== exp_w[i]) begin
        n_bad++; $display("FAIL pp_word%0d: got vld=%b %h want vld=1 %h", i, bus.out_vld, bus.out_data, exp_w[i]);
      end
      @(negedge clk);
    end
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL pp_empty: got %b want 0", bus.out_vld); end
    n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL pp_ovf_err: got %b want 0", ovf_err); end
  endtask

  task automatic test_rst_mid;
    bit got;
    bit seen;
    do_reset();
    drive(1'b1, 32'd1, 1'b0);
    drive(1'b1, 32'd300, 1'b0);
    drive(1'b0, 32'd0, 1'b0);
    idle(1);
    n_cmp++; if (sat_cnt !== 16'd1) begin n_bad++; $display("FAIL mid_sat_pre: got %0d want 1", sat_cnt); end
    drive(1'b1, 32'd2, 1'b0);
    @(negedge clk);
    rst = 1'b1; bus.acc_vld = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL mid_rst_vld: got %b want 0", bus.out_vld); end
    n_cmp++; if (sat_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_rst_sat: got %0d want 0", sat_cnt); end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_vld !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL mid_post_rst: got a word want none"); end
    drive(1'b1, 32'h11, 1'b0);
    drive(1'b1, 32'h12, 1'b0);
    drive(1'b1, 32'h13, 1'b0);
    drive(1'b1, 32'h14, 1'b0);
    drive(1'b0, 32'd0, 1'b0);
    wait_vld(got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL mid_timeout: got no word want out_vld"); end
    n_cmp++; if (bus.out_data !== 32'h14131211) begin n_bad++; $display("FAIL mid_data: got %h want 14131211", bus.out_data); end
    n_cmp++; if (bus.out_cnt !== 3'd4) begin n_bad++; $display("FAIL mid_cnt: got %0d want 4", bus.out_cnt); end
  endtask

  initial begin
    rst = 1'b1; cfg_shift = 5'd0;
    bus.acc_vld = 1'b0; bus.acc = '0; bus.flush = 1'b0; bus.out_rdy = 1'b1;
    test_reset();
    test_packing();
    test_round_sat();
    test_flush();
    test_relu();
    test_overflow();
    test_full_pushpop();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
